// File: rtl/register_file_if.sv
// Bus bundle for the register file: shared data input, operation select,
// per-register enables, the two read selects and the two read ports.
interface register_file_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] i;
  logic [1:0]       funSel;
  logic [3:0]       regSel;
  logic [3:0]       scrSel;
  logic [2:0]       outASel;
  logic [2:0]       outBSel;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;

  // The upstream data mux / sequencer drives operations and read selects.
  modport master (
    output i, funSel, regSel, scrSel, outASel, outBSel,
    input  outA, outB
  );

  // The register file consumes operations and returns both read ports.
  modport slave (
    input  i, funSel, regSel, scrSel, outASel, outBSel,
    output outA, outB
  );
endinterface

// File: rtl/register_file.sv
// Eight WIDTH-bit registers (R1-R4 general purpose, S1-S4 scratch) sharing
// one operation select and one data input, with two combinational read ports.
// Storage index 0-3 holds R1-R4 and 4-7 holds S1-S4, so the 3-bit read select
// indexes the array directly and every code is a valid register.
module register_file #(
  parameter int WIDTH = 16
) (
  input logic             clock,
  input logic             reset,
  register_file_if.slave  bus
);

  localparam logic [1:0] FUN_DEC = 2'b00;
  localparam logic [1:0] FUN_INC = 2'b01;
  localparam logic [1:0] FUN_LD  = 2'b10;
  localparam logic [1:0] FUN_CLR = 2'b11;

  logic [WIDTH-1:0] regs [8];
  logic [7:0]       en;

  assign en = {bus.scrSel, bus.regSel};

  // Apply the shared operation to every enabled register; reset clears all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (en[k]) begin
          case (bus.funSel)
            FUN_DEC: regs[k] <= regs[k] - WIDTH'(1);
            FUN_INC: regs[k] <= regs[k] + WIDTH'(1);
            FUN_LD:  regs[k] <= bus.i;
            FUN_CLR: regs[k] <= '0;
          endcase
        end
      end
    end
  end

  // Read ports are pure muxes of register state; no bypass from i.
  always_comb begin
    bus.outA = regs[bus.outASel];
    bus.outB = regs[bus.outBSel];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized operations, all compared against an array-based reference model.
module tb_register_file;

  localparam int WIDTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  register_file_if #(.WIDTH(WIDTH)) bus ();

  register_file #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 20 ns period; first rising edge at t=10.
  always #10 clock = ~clock;

  logic [WIDTH-1:0] model [8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) model[k] = '0;
  endtask

  // Reference update: what the shared operation does to each enabled register.
  task automatic model_edge();
    logic [7:0] en;
    en = {bus.scrSel, bus.regSel};
    for (int k = 0; k < 8; k++) begin
      if (en[k]) begin
        case (bus.funSel)
          2'd0: model[k] = (model[k] == 16'h0000) ? 16'hFFFF : model[k] - 16'd1;
          2'd1: model[k] = (model[k] == 16'hFFFF) ? 16'h0000 : model[k] + 16'd1;
          2'd2: model[k] = bus.i;
          default: model[k] = 16'h0000;
        endcase
      end
    end
  endtask

  task automatic set_op(input logic [1:0] fun, input logic [3:0] rs, input logic [3:0] ss, input logic [WIDTH-1:0] data);
    bus.funSel = fun;
    bus.regSel = rs;
    bus.scrSel = ss;
    bus.i      = data;
  endtask

  // One rising edge: update the model with the inputs the DUT samples, then settle.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    bus.outASel = a;
    bus.outBSel = b;
    #1;
  endtask

  // Sweep every register through both ports (8 ns, fits inside one cycle).
  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++) begin
      rd(3'(k), 3'(7 - k));
      chk({tag, "_a"}, bus.outA, model[k]);
      chk({tag, "_b"}, bus.outB, model[7 - k]);
    end
  endtask

  initial begin
    set_op(2'b00, 4'b0000, 4'b0000, '0);
    bus.outASel = 3'd0;
    bus.outBSel = 3'd0;
    model_reset();

    // Reset at t=0, checked before the first clock edge.
    #1;
    check_all("rst0");

    // Release reset mid-cycle, then three idle edges.
    @(posedge clock);
    #5 reset = 1'b0;
    @(negedge clock);
    #1;
    for (int n = 0; n < 3; n++) tick();
    check_all("idle");

    // Selective load of R1.
    set_op(2'b10, 4'b0001, 4'b0000, 16'h1234);
    tick();
    set_op(2'b00, 4'b0000, 4'b0000, '0);
    rd(3'd0, 3'd1);
    chk("ld_r1", bus.outA, 16'h1234);
    chk("ld_r2_untouched", bus.outB, 16'h0000);

    // Load S4 only.
    set_op(2'b10, 4'b0000, 4'b1000, 16'hBEEF);
    tick();
    set_op(2'b00, 4'b0000, 4'b0000, '0);
    rd(3'd0, 3'd7);
    chk("ld_s4", bus.outB, 16'hBEEF);
    chk("r1_kept", bus.outA, 16'h1234);

    // Increment wrap and decrement wrap on R2.
    set_op(2'b10, 4'b0010, 4'b0000, 16'hFFFF);
    tick();
    set_op(2'b01, 4'b0010, 4'b0000, '0);
    tick();
    rd(3'd1, 3'd1);
    chk("inc_wrap", bus.outA, 16'h0000);
    set_op(2'b00, 4'b0010, 4'b0000, '0);
    tick();
    rd(3'd1, 3'd0);
    chk("dec_wrap", bus.outA, 16'hFFFF);

    // Counting on R1: 2 -> 0 -> 3.
    set_op(2'b10, 4'b0001, 4'b0000, 16'h0002);
    tick();
    set_op(2'b00, 4'b0001, 4'b0000, '0);
    tick();
    tick();
    rd(3'd0, 3'd0);
    chk("dec_count", bus.outA, 16'h0000);
    set_op(2'b01, 4'b0001, 4'b0000, '0);
    for (int n = 0; n < 3; n++) tick();
    rd(3'd0, 3'd0);
    chk("inc_count", bus.outA, 16'h0003);

    // Broadcast load, partial clear, dual read of S2.
    set_op(2'b10, 4'b1111, 4'b1111, 16'h00AA);
    tick();
    set_op(2'b11, 4'b1111, 4'b0101, '0);
    tick();
    set_op(2'b00, 4'b0000, 4'b0000, '0);
    check_all("clr");
    rd(3'd5, 3'd5);
    chk("dual_a", bus.outA, 16'h00AA);
    chk("dual_b", bus.outB, 16'h00AA);
    rd(3'd4, 3'd6);
    chk("clr_s1", bus.outA, 16'h0000);
    chk("clr_s3", bus.outB, 16'h0000);

    // Asynchronous reset between edges with a load pending.
    set_op(2'b10, 4'b1111, 4'b0000, 16'h5555);
    #1 reset = 1'b1;
    model_reset();
    check_all("rst_async");
    reset = 1'b0;
    tick();
    check_all("post_rst");
    rd(3'd3, 3'd4);
    chk("post_rst_r4", bus.outA, 16'h5555);
    chk("post_rst_s1", bus.outB, 16'h0000);

    // Randomized operations against the model.
    for (int n = 0; n < 400; n++) begin
      set_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 16'($urandom));
      // Bias some registers near the wrap points.
      if (n % 50 == 0) set_op(2'b10, 4'($urandom), 4'($urandom), (n % 100 == 0) ? 16'hFFFF : 16'h0000);
      tick();
      rd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      chk("rnd_a", bus.outA, model[bus.outASel]);
      chk("rnd_b", bus.outB, model[bus.outBSel]);
      if (n % 40 == 39) check_all("rnd_all");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
